mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and data ports; data wins ties.
// Branch flushes cancel an in-flight fetch without aborting the memory transaction.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              flush,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_DELAY + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_DELAY - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          cancel;
  logic          busy;
  logic          last;
  logic          grant_d;
  logic          grant_i;

  assign busy = (state != IDLE);
  assign last = busy && (cnt == LAST);

  // On a completion edge only the other port may be granted, giving back-to-back service.
  assign grant_d = d_req && ((state == IDLE) || (last && state == BUSY_I));
  assign grant_i = !grant_d && if_req && !flush &&
                   ((state == IDLE) || (last && state == BUSY_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cancel    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (grant_d) begin
      state     <= BUSY_D;
      cnt       <= '0;
      cancel    <= 1'b0;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_we    <= d_we;
    end else if (grant_i) begin
      state     <= BUSY_I;
      cnt       <= '0;
      cancel    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (last) begin
      state  <= IDLE;
      cnt    <= '0;
      cancel <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (state == BUSY_I && flush)
        cancel <= 1'b1;
    end
  end

  assign mem_req  = busy && (cnt == '0);
  assign if_done  = last && (state == BUSY_I) && !cancel;
  assign d_done   = last && (state == BUSY_D);
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign stall_f  = if_req && !if_done;
  assign stall_m  = d_req && !d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table and random traffic on MEM_DELAY=4,
// plus a hand-written back-to-back sequence on a MEM_DELAY=1 instance.
module tb_mem_arbiter;

  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // MEM_DELAY=4 instance
  logic        rst, if_req, if_done, d_req, d_we, d_done, flush, stall_f, stall_m, mem_req, mem_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DELAY(D)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .flush(flush),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // MEM_DELAY=1 instance
  logic        rst1, if_req1, if_done1, d_req1, d_we1, d_done1, flush1, stall_f1, stall_m1, mem_req1, mem_we1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DELAY(1)) dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_done(d_done1), .d_rdata(d_rdata1), .flush(flush1),
    .stall_f(stall_f1), .stall_m(stall_m1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  function automatic logic [31:0] mem_val(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Memory model: read data appears D-1 cycles after the request cycle, junk otherwise.
  logic [31:0] rd_at [int];
  task automatic mem_env();
    if (mem_req) rd_at[cyc + D - 1] = mem_val(mem_addr);
    if (rd_at.exists(cyc)) begin
      mem_rdata = rd_at[cyc];
      rd_at.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
  endtask

  typedef struct {
    logic        r, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    logic        fl;
    logic [5:0]  e;    // {mem_req, mem_we, if_done, d_done, stall_f, stall_m}
    logic [31:0] ea, ewd;
  } vec_t;
  vec_t tv[$];

  task automatic add(logic r, logic ir, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da,
                     logic [31:0] dwd, logic fl, logic [5:0] e, logic [31:0] ea, logic [31:0] ewd);
    vec_t v;
    v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.fl = fl; v.e = e; v.ea = ea; v.ewd = ewd;
    tv.push_back(v);
  endtask

  task automatic step1(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                       logic [4:0] e, logic [31:0] ea);
    @(negedge clk);
    if_req1 = ir; if_addr1 = ia; d_req1 = dr; d_addr1 = da;
    #1;
    mem_rdata1 = mem_req1 ? mem_val(mem_addr1) : $urandom;
    #1;
    chk("d1_mem_req", mem_req1, e[4]);
    if (e[4]) begin
      chk("d1_mem_addr", mem_addr1, ea);
      chk("d1_mem_we", mem_we1, 0);
      chk("d1_mem_wdata", mem_wdata1, 0);
    end
    chk("d1_if_done", if_done1, e[3]);
    if (e[3]) chk("d1_if_rdata", if_rdata1, mem_val(ea));
    chk("d1_d_done", d_done1, e[2]);
    if (e[2]) chk("d1_d_rdata", d_rdata1, mem_val(ea));
    chk("d1_stall_f", stall_f1, e[1]);
    chk("d1_stall_m", stall_m1, e[0]);
  endtask

  logic [31:0] cur;
  int          owner, gcyc, age;
  bit          canc, mwe_m, done_m, e_id, e_dd, e_mreq, i_end, d_end;
  logic [31:0] maddr_m, mwd_m;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; flush = 0;
    mem_rdata = 0;
    rst1 = 1; if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    flush1 = 0; mem_rdata1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_dones", {if_done, d_done}, 0);
    rst = 0; rst1 = 0;

    add(0,0,0,0,0,0,0,0, 6'b000000, 0, 0);
    // single fetch
    add(0,1,32'h100,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h100,0,0,0,0,0, 6'b100010, 32'h100, 0);
    add(0,1,32'h100,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h100,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h100,0,0,0,0,0, 6'b001000, 0, 0);
    add(0,0,0,0,0,0,0,0, 6'b000000, 0, 0);
    // contention: store first, then fetch back-to-back
    add(0,1,32'h300,1,1,32'h200,32'hDEADBEEF,0, 6'b000011, 0, 0);
    add(0,1,32'h300,1,1,32'h200,32'hDEADBEEF,0, 6'b110011, 32'h200, 32'hDEADBEEF);
    add(0,1,32'h300,1,1,32'h200,32'hDEADBEEF,0, 6'b000011, 0, 0);
    add(0,1,32'h300,1,1,32'h200,32'hDEADBEEF,0, 6'b000011, 0, 0);
    add(0,1,32'h300,1,1,32'h200,32'hDEADBEEF,0, 6'b000110, 0, 0);
    add(0,1,32'h300,0,0,0,0,0, 6'b100010, 32'h300, 0);
    add(0,1,32'h300,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h300,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h300,0,0,0,0,0, 6'b001000, 0, 0);
    add(0,0,0,0,0,0,0,0, 6'b000000, 0, 0);
    // flush at cnt=1 cancels the fetch; pending load follows directly
    add(0,1,32'h400,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h400,1,0,32'h500,0,0, 6'b100011, 32'h400, 0);
    add(0,1,32'h400,1,0,32'h500,0,1, 6'b000011, 0, 0);
    add(0,1,32'h400,1,0,32'h500,0,0, 6'b000011, 0, 0);
    add(0,1,32'h400,1,0,32'h500,0,0, 6'b000011, 0, 0);
    add(0,0,0,1,0,32'h500,0,0, 6'b100001, 32'h500, 0);
    add(0,0,0,1,0,32'h500,0,0, 6'b000001, 0, 0);
    add(0,0,0,1,0,32'h500,0,0, 6'b000001, 0, 0);
    add(0,0,0,1,0,32'h500,0,0, 6'b000100, 0, 0);
    add(0,0,0,0,0,0,0,0, 6'b000000, 0, 0);
    // flush in idle blocks the grant for that edge only
    add(0,1,32'h600,0,0,0,0,1, 6'b000010, 0, 0);
    add(0,1,32'h600,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h600,0,0,0,0,0, 6'b100010, 32'h600, 0);
    add(0,1,32'h600,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h600,0,0,0,0,0, 6'b000010, 0, 0);
    add(0,1,32'h600,0,0,0,0,0, 6'b001000, 0, 0);
    add(0,0,0,0,0,0,0,0, 6'b000000, 0, 0);
    // reset at BUSY_D cnt=2 abandons the store; the held request is re-granted
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b000001, 0, 0);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b110001, 32'h700, 32'h12345678);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b000001, 0, 0);
    add(1,0,0,1,1,32'h700,32'h12345678,0, 6'b000001, 0, 0);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b000001, 0, 0);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b110001, 32'h700, 32'h12345678);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b000001, 0, 0);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b000001, 0, 0);
    add(0,0,0,1,1,32'h700,32'h12345678,0, 6'b000100, 0, 0);
    add(0,0,0,0,0,0,0,0, 6'b000000, 0, 0);

    cur = 0;
    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].r; if_req = tv[i].ir; if_addr = tv[i].ia; d_req = tv[i].dr; d_we = tv[i].dwe;
      d_addr = tv[i].da; d_wdata = tv[i].dwd; flush = tv[i].fl;
      #1 mem_env();
      #1;
      chk($sformatf("v%0d_mem_req", i), mem_req, tv[i].e[5]);
      if (tv[i].e[5]) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].ea);
        chk($sformatf("v%0d_mem_we", i), mem_we, tv[i].e[4]);
        if (tv[i].e[4]) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tv[i].ewd);
        cur = tv[i].ea;
      end
      chk($sformatf("v%0d_if_done", i), if_done, tv[i].e[3]);
      if (tv[i].e[3]) chk($sformatf("v%0d_if_rdata", i), if_rdata, mem_val(cur));
      chk($sformatf("v%0d_d_done", i), d_done, tv[i].e[2]);
      if (tv[i].e[2] && !tv[i].dwe) chk($sformatf("v%0d_d_rdata", i), d_rdata, mem_val(cur));
      chk($sformatf("v%0d_stall_f", i), stall_f, tv[i].e[1]);
      chk($sformatf("v%0d_stall_m", i), stall_m, tv[i].e[0]);
    end

    // Random traffic against a transaction-level model: who owns memory and since when.
    owner = 0; gcyc = 0; canc = 0; i_end = 0; d_end = 0;
    maddr_m = 0; mwe_m = 0; mwd_m = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (if_req && i_end) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (d_req && d_end) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
      end
      flush = ($urandom_range(0, 6) == 0);
      #1 mem_env();
      #1;
      age    = cyc - gcyc;
      done_m = (owner != 0) && (age == D - 1);
      e_mreq = (owner != 0) && (age == 0);
      e_id   = done_m && owner == 1 && !canc;
      e_dd   = done_m && owner == 2;
      chk("rnd_mem_req", mem_req, e_mreq);
      if (e_mreq) begin
        chk("rnd_mem_addr", mem_addr, maddr_m);
        chk("rnd_mem_we", mem_we, mwe_m);
        if (mwe_m) chk("rnd_mem_wdata", mem_wdata, mwd_m);
      end
      chk("rnd_if_done", if_done, e_id);
      if (e_id) chk("rnd_if_rdata", if_rdata, mem_val(maddr_m));
      chk("rnd_d_done", d_done, e_dd);
      if (e_dd && !mwe_m) chk("rnd_d_rdata", d_rdata, mem_val(maddr_m));
      chk("rnd_stall_f", stall_f, if_req && !e_id);
      chk("rnd_stall_m", stall_m, d_req && !e_dd);

      i_end = done_m && owner == 1;
      d_end = done_m && owner == 2;
      if (owner != 0 && !done_m) begin
        if (owner == 1 && flush) canc = 1;
      end else if (d_req && owner != 2) begin
        owner = 2; gcyc = cyc + 1; canc = 0; maddr_m = d_addr; mwe_m = d_we; mwd_m = d_wdata;
      end else if (if_req && !flush && owner != 1) begin
        owner = 1; gcyc = cyc + 1; canc = 0; maddr_m = if_addr; mwe_m = 0; mwd_m = 0;
      end else begin
        owner = 0;
      end
    end

    // MEM_DELAY=1: done shares the request cycle; ports alternate on completion edges.
    step1(1, 32'h20, 1, 32'h10, 5'b00011, 0);
    step1(1, 32'h20, 1, 32'h10, 5'b10110, 32'h10);
    step1(1, 32'h20, 1, 32'h11, 5'b11001, 32'h20);
    step1(0, 32'h0,  1, 32'h11, 5'b10100, 32'h11);
    step1(0, 32'h0,  1, 32'h12, 5'b00001, 0);
    step1(0, 32'h0,  1, 32'h12, 5'b10100, 32'h12);
    step1(0, 32'h0,  0, 32'h0,  5'b00000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
